// File: rtl/keypad_seq_divider_if.sv
// Key-pulse input and result/status bus between the keypad decoder and keypad_seq_divider.
// master = key source / display side, slave = divider core.
interface keypad_seq_divider_if #(
    parameter int unsigned W = 8
);
    logic         key_valid;
    logic [3:0]   key_value;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [W-1:0] display_value;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         entry_ovf;
    logic         rem_sel;
    logic [1:0]   state_dbg;

    modport master (
        output key_valid, key_value,
        input  operand_a, operand_b, quotient, remainder, display_value,
        input  busy, done, div_by_zero, entry_ovf, rem_sel, state_dbg
    );

    modport slave (
        input  key_valid, key_value,
        output operand_a, operand_b, quotient, remainder, display_value,
        output busy, done, div_by_zero, entry_ovf, rem_sel, state_dbg
    );
endinterface

// File: rtl/keypad_seq_divider.sv
// Keypad-driven decimal operand entry with a W-cycle sequential restoring divider.
// Optional feature macro KPD_DIV_REM_SEL_EN: KEY_SEL in RESULT toggles quotient/remainder display.
module keypad_seq_divider #(
    parameter int unsigned W         = 8,
    parameter logic [3:0]  KEY_ENTER = 4'hA,
    parameter logic [3:0]  KEY_EQ    = 4'hB,
    parameter logic [3:0]  KEY_CLR   = 4'hC,
    parameter logic [3:0]  KEY_SEL   = 4'hD
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_seq_divider_if.slave  bus
);
    localparam int unsigned CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = W[CW-1:0];
    localparam int unsigned TEN_I    = 10;
    localparam logic [W+3:0] TEN     = TEN_I[W+3:0];

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_DIVIDE  = 2'd2,
        ST_RESULT  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [W-1:0]  r_a, w_a_nxt;
    logic [W-1:0]  r_b, w_b_nxt;
    logic [W-1:0]  r_q, w_q_nxt;
    logic [W-1:0]  r_r, w_r_nxt;
    logic [W-1:0]  r_disp_hold, w_disp;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_dbz, w_dbz_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          r_rem_sel, w_rem_sel_nxt;
    logic [W-1:0]  r_dv_num, w_dv_num_nxt;
    logic [W-1:0]  r_dv_rem, w_dv_rem_nxt;
    logic [W-1:0]  r_dv_den, w_dv_den_nxt;
    logic [CW-1:0] r_dv_cnt, w_dv_cnt_nxt;

    logic          w_key_digit;
    logic          w_key_clr;
    logic [W-1:0]  w_digit;
    logic [W+3:0]  w_digit_ext;
    logic [W-1:0]  w_acc_in;
    logic [W+3:0]  w_acc_ext;
    logic          w_acc_ovf;
    logic [W:0]    w_trial;

    assign w_key_digit = bus.key_valid && (bus.key_value <= 4'd9);
    assign w_key_clr   = bus.key_valid && (bus.key_value == KEY_CLR);

    always_comb begin
        w_digit          = '0;
        w_digit[3:0]     = bus.key_value;
        w_digit_ext      = '0;
        w_digit_ext[3:0] = bus.key_value;
    end

    // Digit append in W+4 bits so that acc*10+9 can never wrap before the range check.
    assign w_acc_in  = (r_state == ST_ENTER_B) ? r_b : r_a;
    assign w_acc_ext = {4'b0000, w_acc_in} * TEN + w_digit_ext;
    assign w_acc_ovf = |w_acc_ext[W+3:W];

    // Restoring step: partial remainder stays below the divisor, so bit W of the trial is the borrow.
    assign w_trial = {r_dv_rem, r_dv_num[W-1]} - {1'b0, r_dv_den};

    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_q_nxt       = r_q;
        w_r_nxt       = r_r;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_dbz_nxt     = r_dbz;
        w_ovf_nxt     = r_ovf;
        w_rem_sel_nxt = r_rem_sel;
        w_dv_num_nxt  = r_dv_num;
        w_dv_rem_nxt  = r_dv_rem;
        w_dv_den_nxt  = r_dv_den;
        w_dv_cnt_nxt  = r_dv_cnt;

        unique case (r_state)
            ST_ENTER_A, ST_ENTER_B: begin
                if (w_key_digit) begin
                    if (w_acc_ovf) begin
                        w_ovf_nxt = 1'b1;
                    end else if (r_state == ST_ENTER_A) begin
                        w_a_nxt = w_acc_ext[W-1:0];
                    end else begin
                        w_b_nxt = w_acc_ext[W-1:0];
                    end
                end else if (bus.key_valid && (bus.key_value == KEY_ENTER) && (r_state == ST_ENTER_A)) begin
                    w_state_nxt = ST_ENTER_B;
                end
            end
            ST_DIVIDE: begin
                if (r_dv_cnt != CNT_LAST) begin
                    w_dv_cnt_nxt = r_dv_cnt + 1'b1;
                    if (!w_trial[W]) begin
                        w_dv_rem_nxt = w_trial[W-1:0];
                        w_dv_num_nxt = {r_dv_num[W-2:0], 1'b1};
                    end else begin
                        w_dv_rem_nxt = {r_dv_rem[W-2:0], r_dv_num[W-1]};
                        w_dv_num_nxt = {r_dv_num[W-2:0], 1'b0};
                    end
                end else begin
                    w_q_nxt     = r_dv_num;
                    w_r_nxt     = r_dv_rem;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (w_key_digit) begin
                    w_a_nxt       = w_digit;
                    w_b_nxt       = '0;
                    w_dbz_nxt     = 1'b0;
                    w_ovf_nxt     = 1'b0;
                    w_rem_sel_nxt = 1'b0;
                    w_state_nxt   = ST_ENTER_A;
                end else if (bus.key_valid && (bus.key_value == KEY_SEL)) begin
`ifdef KPD_DIV_REM_SEL_EN
                    w_rem_sel_nxt = ~r_rem_sel;
`else
                    w_rem_sel_nxt = 1'b0;
`endif
                end
            end
            default: w_state_nxt = ST_ENTER_A;
        endcase

        // KEY_EQ from ENTER_B starts a division; from RESULT it repeats with the same operands.
        if (bus.key_valid && (bus.key_value == KEY_EQ) &&
            ((r_state == ST_ENTER_B) || (r_state == ST_RESULT))) begin
            if (r_b == '0) begin
                w_q_nxt     = '1;
                w_r_nxt     = r_a;
                w_dbz_nxt   = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_RESULT;
            end else begin
                w_dv_num_nxt = r_a;
                w_dv_rem_nxt = '0;
                w_dv_den_nxt = r_b;
                w_dv_cnt_nxt = '0;
                w_busy_nxt   = 1'b1;
                w_state_nxt  = ST_DIVIDE;
            end
        end

        if (w_key_clr) begin
            w_a_nxt       = '0;
            w_b_nxt       = '0;
            w_q_nxt       = '0;
            w_r_nxt       = '0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_dbz_nxt     = 1'b0;
            w_ovf_nxt     = 1'b0;
            w_rem_sel_nxt = 1'b0;
            w_state_nxt   = ST_ENTER_A;
        end
    end

    always_comb begin
        w_disp = r_disp_hold;
        unique case (r_state)
            ST_ENTER_A: w_disp = r_a;
            ST_ENTER_B: w_disp = r_b;
            ST_DIVIDE:  w_disp = r_disp_hold;
            ST_RESULT:  w_disp = r_rem_sel ? r_r : r_q;
            default:    w_disp = r_disp_hold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_ENTER_A;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_disp_hold <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_rem_sel   <= 1'b0;
            r_dv_num    <= '0;
            r_dv_rem    <= '0;
            r_dv_den    <= '0;
            r_dv_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_q         <= w_q_nxt;
            r_r         <= w_r_nxt;
            r_disp_hold <= w_disp;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_dbz       <= w_dbz_nxt;
            r_ovf       <= w_ovf_nxt;
            r_rem_sel   <= w_rem_sel_nxt;
            r_dv_num    <= w_dv_num_nxt;
            r_dv_rem    <= w_dv_rem_nxt;
            r_dv_den    <= w_dv_den_nxt;
            r_dv_cnt    <= w_dv_cnt_nxt;
        end
    end

    assign bus.operand_a     = r_a;
    assign bus.operand_b     = r_b;
    assign bus.quotient      = r_q;
    assign bus.remainder     = r_r;
    assign bus.display_value = w_disp;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.div_by_zero   = r_dbz;
    assign bus.entry_ovf     = r_ovf;
    assign bus.rem_sel       = r_rem_sel;
    assign bus.state_dbg     = r_state;
endmodule

// File: tb/tb_keypad_seq_divider.sv
// Directed bench for keypad_seq_divider at W=8; expected values are hand-computed per scenario.
// Builds with or without KPD_DIV_REM_SEL_EN.
module tb_keypad_seq_divider;
    localparam int unsigned W = 8;

`ifdef KPD_DIV_REM_SEL_EN
    localparam logic [7:0] EXP_SEL_DISP = 8'd4;
    localparam logic       EXP_SEL_RS   = 1'b1;
`else
    localparam logic [7:0] EXP_SEL_DISP = 8'd17;
    localparam logic       EXP_SEL_RS   = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    keypad_seq_divider_if #(.W(W)) bus ();

    keypad_seq_divider #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the key is sampled on the following posedge.
    task automatic press(input logic [3:0] k);
        bus.key_value = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_value = 4'h0;
    endtask

    // Cycles until done (or -1 after 40); glitch flags a result change or busy drop before done.
    task automatic wait_done(output int lat, output bit glitch);
        logic [7:0] q0, r0;
        q0 = bus.quotient;
        r0 = bus.remainder;
        lat = -1;
        glitch = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
            if ((bus.quotient !== q0) || (bus.remainder !== r0) || (bus.busy !== 1'b1)) glitch = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_value = 4'd5;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({bus.operand_a, bus.operand_b, bus.quotient, bus.remainder, bus.display_value, bus.busy,
                      bus.done, bus.div_by_zero, bus.entry_ovf, bus.rem_sel, bus.state_dbg} !== '0) begin
            n_err++; $display("FAIL reset_all_zero a=%0d b=%0d q=%0d r=%0d st=%0d exp all 0",
                bus.operand_a, bus.operand_b, bus.quotient, bus.remainder, bus.state_dbg);
        end
        bus.key_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divide();
        int lat; bit glitch;
        press(4'd1); press(4'd2); press(4'd3);
        n_cmp++; if (bus.display_value !== 8'd123) begin n_err++; $display("FAIL entry_a_disp got %0d exp 123", bus.display_value); end
        press(4'hA); press(4'd7);
        n_cmp++; if ({bus.state_dbg, bus.operand_b, bus.display_value} !== {2'd1, 8'd7, 8'd7}) begin
            n_err++; $display("FAIL entry_b st=%0d b=%0d disp=%0d exp 1/7/7", bus.state_dbg, bus.operand_b, bus.display_value); end
        press(4'hB);
        n_cmp++; if ({bus.busy, bus.state_dbg, bus.display_value} !== {1'b1, 2'd2, 8'd7}) begin
            n_err++; $display("FAIL div_start busy=%0d st=%0d disp=%0d exp 1/2/7", bus.busy, bus.state_dbg, bus.display_value); end
        wait_done(lat, glitch);
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL div_latency got %0d exp 9", lat); end
        n_cmp++; if (glitch !== 1'b0) begin n_err++; $display("FAIL div_hold got %0d exp 0", glitch); end
        n_cmp++; if ({bus.quotient, bus.remainder, bus.display_value, bus.state_dbg, bus.busy} !== {8'd17, 8'd4, 8'd17, 2'd3, 1'b0}) begin
            n_err++; $display("FAIL div_result q=%0d r=%0d disp=%0d st=%0d busy=%0d exp 17/4/17/3/0",
                bus.quotient, bus.remainder, bus.display_value, bus.state_dbg, bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse got %0d exp 0", bus.done); end
    endtask

    task automatic test_rem_sel();
        press(4'hD);
        n_cmp++; if ({bus.display_value, bus.rem_sel} !== {EXP_SEL_DISP, EXP_SEL_RS}) begin
            n_err++; $display("FAIL sel_1 disp=%0d rs=%0d exp %0d/%0d", bus.display_value, bus.rem_sel, EXP_SEL_DISP, EXP_SEL_RS); end
        press(4'hD);
        n_cmp++; if ({bus.display_value, bus.rem_sel} !== {8'd17, 1'b0}) begin
            n_err++; $display("FAIL sel_2 disp=%0d rs=%0d exp 17/0", bus.display_value, bus.rem_sel); end
    endtask

    task automatic test_back_to_back();
        int lat; bit glitch;
        press(4'hB);
        n_cmp++; if ({bus.busy, bus.display_value} !== {1'b1, 8'd17}) begin
            n_err++; $display("FAIL repeat_start busy=%0d disp=%0d exp 1/17", bus.busy, bus.display_value); end
        press(4'd5);
        wait_done(lat, glitch);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL repeat_latency got %0d exp 8", lat); end
        n_cmp++; if ({bus.operand_a, bus.quotient, bus.remainder} !== {8'd123, 8'd17, 8'd4}) begin
            n_err++; $display("FAIL repeat_result a=%0d q=%0d r=%0d exp 123/17/4", bus.operand_a, bus.quotient, bus.remainder); end
    endtask

    task automatic test_clear();
        press(4'hC);
        n_cmp++; if ({bus.operand_a, bus.operand_b, bus.quotient, bus.remainder, bus.state_dbg, bus.done} !== '0) begin
            n_err++; $display("FAIL clear a=%0d b=%0d q=%0d r=%0d st=%0d exp all 0",
                bus.operand_a, bus.operand_b, bus.quotient, bus.remainder, bus.state_dbg); end
    endtask

    task automatic test_div_by_zero();
        press(4'd5); press(4'hA); press(4'd0); press(4'hB);
        n_cmp++; if ({bus.done, bus.div_by_zero, bus.quotient, bus.remainder, bus.busy, bus.state_dbg} !==
                     {1'b1, 1'b1, 8'd255, 8'd5, 1'b0, 2'd3}) begin
            n_err++; $display("FAIL dbz done=%0d dbz=%0d q=%0d r=%0d busy=%0d st=%0d exp 1/1/255/5/0/3",
                bus.done, bus.div_by_zero, bus.quotient, bus.remainder, bus.busy, bus.state_dbg); end
        @(negedge clk);
        n_cmp++; if ({bus.done, bus.div_by_zero, bus.busy} !== {1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL dbz_after done=%0d dbz=%0d busy=%0d exp 0/1/0", bus.done, bus.div_by_zero, bus.busy); end
    endtask

    task automatic test_chain();
        press(4'd9);
        n_cmp++; if ({bus.state_dbg, bus.operand_a, bus.operand_b, bus.div_by_zero, bus.quotient} !==
                     {2'd0, 8'd9, 8'd0, 1'b0, 8'd255}) begin
            n_err++; $display("FAIL chain st=%0d a=%0d b=%0d dbz=%0d q=%0d exp 0/9/0/0/255",
                bus.state_dbg, bus.operand_a, bus.operand_b, bus.div_by_zero, bus.quotient); end
    endtask

    task automatic test_entry_ovf();
        press(4'hC);
        press(4'd2); press(4'd5); press(4'd6);
        n_cmp++; if ({bus.operand_a, bus.entry_ovf} !== {8'd25, 1'b1}) begin
            n_err++; $display("FAIL ovf_reject a=%0d ovf=%0d exp 25/1", bus.operand_a, bus.entry_ovf); end
        press(4'd5);
        n_cmp++; if ({bus.operand_a, bus.entry_ovf, bus.display_value} !== {8'd255, 1'b1, 8'd255}) begin
            n_err++; $display("FAIL ovf_max a=%0d ovf=%0d disp=%0d exp 255/1/255", bus.operand_a, bus.entry_ovf, bus.display_value); end
        press(4'hC);
        n_cmp++; if (bus.entry_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %0d exp 0", bus.entry_ovf); end
    endtask

    task automatic test_abort();
        int seen;
        press(4'd9); press(4'd9); press(4'hA); press(4'd4); press(4'hB);
        @(negedge clk);
        @(negedge clk);
        press(4'hC);
        n_cmp++; if ({bus.busy, bus.quotient, bus.state_dbg, bus.done} !== {1'b0, 8'd0, 2'd0, 1'b0}) begin
            n_err++; $display("FAIL abort busy=%0d q=%0d st=%0d done=%0d exp 0/0/0/0", bus.busy, bus.quotient, bus.state_dbg, bus.done); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done got %0d exp 0", seen); end
    endtask

    task automatic test_reset_mid_divide();
        press(4'd1); press(4'd2); press(4'd3); press(4'hA); press(4'd7); press(4'hB);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.operand_a, bus.operand_b, bus.quotient, bus.remainder, bus.display_value, bus.busy,
                      bus.done, bus.div_by_zero, bus.entry_ovf, bus.rem_sel, bus.state_dbg} !== '0) begin
            n_err++; $display("FAIL reset_mid a=%0d b=%0d busy=%0d st=%0d exp all 0",
                bus.operand_a, bus.operand_b, bus.busy, bus.state_dbg); end
        rst = 1'b1;
        repeat (12) @(negedge clk);
        n_cmp++; if ({bus.done, bus.quotient} !== {1'b0, 8'd0}) begin
            n_err++; $display("FAIL reset_mid_quiet done=%0d q=%0d exp 0/0", bus.done, bus.quotient); end
        press(4'd9);
        n_cmp++; if ({bus.operand_a, bus.operand_b} !== {8'd9, 8'd0}) begin
            n_err++; $display("FAIL reset_mid_entry a=%0d b=%0d exp 9/0", bus.operand_a, bus.operand_b); end
    endtask

    task automatic test_ignored_keys();
        press(4'hB);
        n_cmp++; if ({bus.state_dbg, bus.busy} !== {2'd0, 1'b0}) begin
            n_err++; $display("FAIL eq_in_a st=%0d busy=%0d exp 0/0", bus.state_dbg, bus.busy); end
        press(4'hA); press(4'hA); press(4'hD); press(4'hE);
        n_cmp++; if ({bus.state_dbg, bus.rem_sel, bus.operand_a, bus.operand_b} !== {2'd1, 1'b0, 8'd9, 8'd0}) begin
            n_err++; $display("FAIL keys_in_b st=%0d rs=%0d a=%0d b=%0d exp 1/0/9/0",
                bus.state_dbg, bus.rem_sel, bus.operand_a, bus.operand_b); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_value = 4'h0;
        @(negedge clk);
        test_reset();
        test_divide();
        test_rem_sel();
        test_back_to_back();
        test_clear();
        test_div_by_zero();
        test_chain();
        test_entry_ovf();
        test_abort();
        test_reset_mid_divide();
        test_ignored_keys();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
